seq_alu: RTL
============

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width; SHALL be a power of two, 4..64.
REQ-002 Derived localparam SHW = $clog2(WIDTH), shift-amount width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 a  input  WIDTH  operand A, unsigned.
REQ-008 b  input  WIDTH  operand B, unsigned; b[SHW-1:0] is the shift amount for shifts.
REQ-009 op_code  input  4  operation select.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer takes result.
REQ-012 result  output  WIDTH  operation result.
REQ-013 carry  output  1  carry/borrow/shift-out flag.
REQ-014 zero  output  1  result == 0.
REQ-015 err  output  1  illegal op_code flag.

Function
REQ-016 Opcodes SHALL be: 0 ADD, 1 SUB, 2 SLL, 3 SRL, 4 AND, 5 OR, 6 XOR, 7 EQL, 8 MUL, 9 SRA; 10-15 illegal.
REQ-017 FSM SHALL have states IDLE, BUSY, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-018 Acceptance SHALL occur on a rising edge with in_valid && in_ready; a, b, op_code latched then; later input changes ignored.
REQ-019 Single-cycle ops (ADD, SUB, AND, OR, XOR, EQL, illegal, and shifts with amount 0): IDLE -> DONE; out_valid high 1 cycle after the acceptance edge.
REQ-020 Shifts with amount s > 0: IDLE -> BUSY, one bit position per cycle; out_valid high s+1 cycles after acceptance.
REQ-021 MUL: shift-add, one multiplier bit per cycle, WIDTH cycles in BUSY; out_valid high WIDTH+1 cycles after acceptance; result = low WIDTH bits of a*b.
REQ-022 DONE -> IDLE on out_valid && out_ready; no new acceptance in that same cycle (min. 2 cycles per op).
REQ-023 In DONE, result, carry, zero, err SHALL stay stable until the handshake completes.
REQ-024 ADD: result = (a+b) mod 2^WIDTH, carry = bit WIDTH of the sum.
REQ-025 SUB: result = (a-b) mod 2^WIDTH, carry = 1 iff a < b (borrow).
REQ-026 SLL/SRL: zero fill; SRA: fill with a[WIDTH-1]; carry = last bit shifted out, 0 when s = 0.
REQ-027 AND/OR/XOR bitwise; EQL: result = 1 if a == b else 0; carry = 0 for these and for MUL.
REQ-028 zero = (result == 0) for every op, including illegal.
REQ-029 Illegal op: result = 0, carry = 0, err = 1; err = 0 for all legal ops.

Reset
REQ-030 On rst_n low, the FSM SHALL go to IDLE immediately (asynchronous), including mid-BUSY or mid-DONE, with the operation discarded.
REQ-031 Reset values: in_ready = 1, out_valid = 0, result = 0, carry = 0, zero = 0, err = 0, internal counter/accumulator = 0.
REQ-032 First acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Verification (WIDTH = 8)
REQ-033 ADD a=0xFF b=0x01, out_ready=1 -> one cycle later: out_valid=1, result=0x00, carry=1, zero=1, err=0.
REQ-034 SUB a=0x03 b=0x05 -> result=0xFE, carry=1, zero=0; then SLL a=0x81 b=3 -> out_valid 4 cycles after acceptance, result=0x08, carry=0; SRA a=0x80 b=2 -> result=0xE0, carry=0.
REQ-035 MUL a=0x0D b=0x0B -> out_valid exactly 9 cycles after acceptance, result=0x8F, carry=0.
REQ-036 Backpressure: ADD 0x10+0x20 with out_ready=0 for 5 cycles -> result held at 0x30, out_valid=1, in_ready=0 throughout; IDLE the cycle after out_ready=1.
REQ-037 Reset mid-MUL: assert rst_n=0 at cycle 4 of BUSY -> all outputs at reset values immediately; in_ready=1; no stale out_valid after release.
REQ-038 Illegal op_code=0xF with a=0x55 -> result=0x00, err=1, zero=1, carry=0, latency 1 cycle.

Source files
------------

// File: rtl/seq_alu.sv
// Sequential ALU with a valid/ready handshake on both sides.
// Shifts and multiply iterate one bit per cycle; everything else finishes in one cycle.
module seq_alu #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             err
);

    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned CW  = SHW + 1;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_SLL = 4'd2;
    localparam logic [3:0] OP_SRL = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_EQL = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [3:0] OP_SRA = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [3:0]       op_q, op_n;
    logic [WIDTH-1:0] work_q, work_n;      // shift operand, or multiplicand
    logic [WIDTH-1:0] mplier_q, mplier_n;  // remaining multiplier bits
    logic [WIDTH-1:0] acc_q, acc_n;        // partial product
    logic [CW-1:0]    cnt_q, cnt_n;        // iterations left in BUSY
    logic [WIDTH-1:0] result_n;
    logic             carry_n, zero_n, err_n;

    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   sum, diff;
    logic [WIDTH-1:0] fast_res;
    logic             fast_carry, fast_err, needs_busy;
    logic [WIDTH-1:0] acc_step, shifted;
    logic             shout;

    // Result of every op that completes in the acceptance cycle
    always_comb begin
        shamt      = b[SHW-1:0];
        sum        = {1'b0, a} + {1'b0, b};
        diff       = {1'b0, a} - {1'b0, b};
        fast_res   = '0;
        fast_carry = 1'b0;
        fast_err   = 1'b0;
        needs_busy = 1'b0;
        case (op_code)
            OP_ADD: begin
                fast_res   = sum[WIDTH-1:0];
                fast_carry = sum[WIDTH];
            end
            OP_SUB: begin
                fast_res   = diff[WIDTH-1:0];
                fast_carry = diff[WIDTH];
            end
            OP_SLL, OP_SRL, OP_SRA: begin
                fast_res   = a;
                needs_busy = (shamt != '0);
            end
            OP_AND: fast_res = a & b;
            OP_OR:  fast_res = a | b;
            OP_XOR: fast_res = a ^ b;
            OP_EQL: fast_res = WIDTH'(a == b);
            OP_MUL: needs_busy = 1'b1;
            default: fast_err = 1'b1;
        endcase
    end

    // One iteration step of the multi-cycle ops
    always_comb begin
        acc_step = acc_q + (mplier_q[0] ? work_q : '0);
        case (op_q)
            OP_SLL: begin
                shout   = work_q[WIDTH-1];
                shifted = {work_q[WIDTH-2:0], 1'b0};
            end
            OP_SRL: begin
                shout   = work_q[0];
                shifted = {1'b0, work_q[WIDTH-1:1]};
            end
            default: begin
                shout   = work_q[0];
                shifted = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
            end
        endcase
    end

    // Next state and next datapath values
    always_comb begin
        state_n  = state;
        op_n     = op_q;
        work_n   = work_q;
        mplier_n = mplier_q;
        acc_n    = acc_q;
        cnt_n    = cnt_q;
        result_n = result;
        carry_n  = carry;
        zero_n   = zero;
        err_n    = err;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    op_n = op_code;
                    if (needs_busy) begin
                        state_n  = BUSY;
                        work_n   = a;
                        mplier_n = b;
                        acc_n    = '0;
                        cnt_n    = (op_code == OP_MUL) ? CW'(WIDTH) : CW'(shamt);
                    end else begin
                        state_n  = DONE;
                        result_n = fast_res;
                        carry_n  = fast_carry;
                        zero_n   = (fast_res == '0);
                        err_n    = fast_err;
                    end
                end
            end
            BUSY: begin
                cnt_n = cnt_q - CW'(1);
                if (op_q == OP_MUL) begin
                    acc_n    = acc_step;
                    work_n   = {work_q[WIDTH-2:0], 1'b0};
                    mplier_n = {1'b0, mplier_q[WIDTH-1:1]};
                end else begin
                    work_n = shifted;
                end
                if (cnt_q == CW'(1)) begin
                    state_n  = DONE;
                    result_n = (op_q == OP_MUL) ? acc_step : shifted;
                    carry_n  = (op_q == OP_MUL) ? 1'b0 : shout;
                    zero_n   = (((op_q == OP_MUL) ? acc_step : shifted) == '0);
                    err_n    = 1'b0;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_q      <= '0;
            work_q    <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            result    <= '0;
            carry     <= 1'b0;
            zero      <= 1'b0;
            err       <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_n;
            op_q      <= op_n;
            work_q    <= work_n;
            mplier_q  <= mplier_n;
            acc_q     <= acc_n;
            cnt_q     <= cnt_n;
            result    <= result_n;
            carry     <= carry_n;
            zero      <= zero_n;
            err       <= err_n;
            in_ready  <= (state_n == IDLE);
            out_valid <= (state_n == DONE);
        end
    end

endmodule
